// File: rtl/uart_rx_frame_chk.sv
// UART receive frame checker: deserialises strobed line bits LSB first,
// checks parity against the TX convention, and flags parity/stop errors.
module uart_rx_frame_chk #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Bit_Strb,
    input  logic                  Bit_Val,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  Par_Err,
    output logic                  Stp_Err,
    output logic                  Busy
);

    localparam int              CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START_OK,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [DATA_WIDTH-1:0]   pdata_q, pdata_d;
    logic                    dv_q, dv_d;
    logic                    pe_q, pe_d;
    logic                    se_q, se_d;
    logic                    busy_q, busy_d;
    logic                    cfg_en_q, cfg_en_d;
    logic                    cfg_typ_q, cfg_typ_d;
    logic                    par_mis_q, par_mis_d;
    logic                    exp_par;

    // Even type expects XNOR of the data, odd type expects XOR.
    assign exp_par = cfg_typ_q ? (^shift_q) : (~^shift_q);

    // NOTE: every next-state value gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        pdata_d   = pdata_q;
        busy_d    = busy_q;
        cfg_en_d  = cfg_en_q;
        cfg_typ_d = cfg_typ_q;
        par_mis_d = par_mis_q;
        dv_d      = 1'b0;
        pe_d      = 1'b0;
        se_d      = 1'b0;

        if (Bit_Strb) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!Bit_Val) begin
                        state_d   = ST_START_OK;
                        cfg_en_d  = PAR_EN;
                        cfg_typ_d = PAR_TYP;
                        busy_d    = 1'b1;
                        par_mis_d = 1'b0;
                        cnt_d     = '0;
                    end
                end
                // START_OK has already consumed the start bit, so its strobe is data bit 0.
                ST_START_OK, ST_DATA: begin
                    shift_d = {Bit_Val, shift_q[DATA_WIDTH-1:1]};
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = cfg_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = ST_DATA;
                    end
                end
                ST_PARITY: begin
                    par_mis_d = (Bit_Val != exp_par);
                    state_d   = ST_STOP;
                end
                ST_STOP: begin
                    se_d = ~Bit_Val;
                    pe_d = par_mis_q;
                    if (!par_mis_q && Bit_Val) begin
                        pdata_d = shift_q;
                        dv_d    = 1'b1;
                    end
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments only; reset is synchronous.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            pdata_q   <= '0;
            dv_q      <= 1'b0;
            pe_q      <= 1'b0;
            se_q      <= 1'b0;
            busy_q    <= 1'b0;
            cfg_en_q  <= 1'b0;
            cfg_typ_q <= 1'b0;
            par_mis_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            pdata_q   <= pdata_d;
            dv_q      <= dv_d;
            pe_q      <= pe_d;
            se_q      <= se_d;
            busy_q    <= busy_d;
            cfg_en_q  <= cfg_en_d;
            cfg_typ_q <= cfg_typ_d;
            par_mis_q <= par_mis_d;
        end
    end

    assign P_DATA     = pdata_q;
    assign Data_Valid = dv_q;
    assign Par_Err    = pe_q;
    assign Stp_Err    = se_q;
    assign Busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_frame_chk.sv
// Bench for uart_rx_frame_chk: a frame-level model predicts outputs every cycle,
// plus literal checks of key results after each directed frame.
module tb_uart_rx_frame_chk;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         Bit_Strb = 1'b0;
    logic         Bit_Val = 1'b1;
    logic         PAR_EN = 1'b0;
    logic         PAR_TYP = 1'b0;
    logic [W-1:0] P_DATA;
    logic         Data_Valid;
    logic         Par_Err;
    logic         Stp_Err;
    logic         Busy;

    uart_rx_frame_chk #(.DATA_WIDTH(W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Bit_Strb   (Bit_Strb),
        .Bit_Val    (Bit_Val),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .Par_Err    (Par_Err),
        .Stp_Err    (Stp_Err),
        .Busy       (Busy)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    // Model expectations, valid from one posedge+1 to the next.
    logic [W-1:0] exp_pdata = '0;
    logic         exp_dv = 1'b0;
    logic         exp_pe = 1'b0;
    logic         exp_se = 1'b0;
    logic         exp_busy = 1'b0;
    bit           chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Per-cycle compare; pulse expectations last exactly one cycle.
    always @(negedge CLK) begin
        if (chk_en) begin
            check("cyc_pdata", 32'(P_DATA), 32'(exp_pdata));
            check("cyc_dv", 32'(Data_Valid), 32'(exp_dv));
            check("cyc_pe", 32'(Par_Err), 32'(exp_pe));
            check("cyc_se", 32'(Stp_Err), 32'(exp_se));
            check("cyc_busy", 32'(Busy), 32'(exp_busy));
            exp_dv = 1'b0;
            exp_pe = 1'b0;
            exp_se = 1'b0;
        end
    end

    task automatic strobe(input logic b, input int gap);
        repeat (gap) @(posedge CLK);
        @(posedge CLK) #1;
        Bit_Strb = 1'b1;
        Bit_Val  = b;
        @(posedge CLK) #1;
        Bit_Strb = 1'b0;
        Bit_Val  = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge CLK) #1;
        RST = 1'b0;
        @(posedge CLK) #1;
        exp_pdata = '0;
        exp_dv    = 1'b0;
        exp_pe    = 1'b0;
        exp_se    = 1'b0;
        exp_busy  = 1'b0;
        RST = 1'b1;
    endtask

    // Drives a complete frame; the outcome is derived from the frame contents
    // and the configuration in force at the start bit.
    task automatic send_frame(input logic [W-1:0] data, input bit pen, input bit ptyp,
                              input bit pbit, input bit sbit, input int gap, input bit toggle);
        bit par_good;
        bit bad_par;
        PAR_EN  = pen;
        PAR_TYP = ptyp;
        strobe(1'b0, gap);
        exp_busy = 1'b1;
        for (int i = 0; i < W; i++) begin
            if (toggle && i == 3) begin
                PAR_EN  = ~pen;
                PAR_TYP = ~ptyp;
            end
            strobe(data[i], gap);
        end
        if (pen) strobe(pbit, gap);
        strobe(sbit, gap);
        // Odd type wants an odd count of ones in data; even type wants an even count.
        par_good = ptyp ? ($countones(data) % 2 == 1) : ($countones(data) % 2 == 0);
        bad_par  = pen && (pbit != par_good);
        exp_pe   = bad_par;
        exp_se   = !sbit;
        exp_dv   = !bad_par && sbit;
        if (exp_dv) exp_pdata = data;
        exp_busy = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        chk_en = 1'b1;
        RST = 1'b1;
        @(negedge CLK);
        check("rst_pdata", 32'(P_DATA), 32'h0);
        check("rst_busy", 32'(Busy), 32'h0);

        // No parity, 0xA5.
        send_frame(8'hA5, 0, 0, 0, 1, 1, 0);
        @(negedge CLK);
        check("f1_dv", 32'(Data_Valid), 32'h1);
        check("f1_pdata", 32'(P_DATA), 32'hA5);
        check("f1_busy", 32'(Busy), 32'h0);

        // Even type, 0xA5 has four ones: parity bit 1 expected.
        send_frame(8'hA5, 1, 0, 1, 1, 1, 0);
        @(negedge CLK);
        check("f2_dv", 32'(Data_Valid), 32'h1);
        send_frame(8'hA5, 1, 0, 0, 1, 1, 0);
        check("pin_model_pe", 32'(exp_pe), 32'h1);
        @(negedge CLK);
        check("f3_pe", 32'(Par_Err), 32'h1);
        check("f3_dv", 32'(Data_Valid), 32'h0);
        check("f3_pdata", 32'(P_DATA), 32'hA5);

        // Odd type: 0x07 (three ones) good with bit 1; 0x3C (four ones) bad, stop 0.
        send_frame(8'h07, 1, 1, 1, 1, 1, 0);
        @(negedge CLK);
        check("f4_dv", 32'(Data_Valid), 32'h1);
        send_frame(8'h3C, 1, 1, 1, 0, 1, 0);
        check("pin_model_both", 32'({exp_pe, exp_se, exp_dv}), 32'b110);
        @(negedge CLK);
        check("f5_errs", 32'({Par_Err, Stp_Err, Data_Valid}), 32'b110);
        check("f5_pdata", 32'(P_DATA), 32'h07);

        // Idle-line strobes, then 0x5A with config toggled mid-frame.
        for (int i = 0; i < 5; i++) strobe(1'b1, 1);
        @(negedge CLK);
        check("idle_busy", 32'(Busy), 32'h0);
        send_frame(8'h5A, 1, 0, 1, 1, 1, 1);
        @(negedge CLK);
        check("f6_dv", 32'(Data_Valid), 32'h1);
        check("f6_pdata", 32'(P_DATA), 32'h5A);

        // Abort after four data bits with reset.
        PAR_EN = 1'b0;
        strobe(1'b0, 1);
        exp_busy = 1'b1;
        for (int i = 0; i < 4; i++) strobe(1'b1, 1);
        do_reset();
        repeat (3) @(posedge CLK);
        #1;
        send_frame(8'h81, 0, 0, 0, 1, 1, 0);
        @(negedge CLK);
        check("f7_dv", 32'(Data_Valid), 32'h1);
        check("f7_pdata", 32'(P_DATA), 32'h81);

        // Back-to-back frames, one strobe every 3 cycles.
        send_frame(8'h11, 0, 0, 0, 1, 1, 0);
        @(negedge CLK);
        check("f8_pdata", 32'(P_DATA), 32'h11);
        send_frame(8'hEE, 0, 0, 0, 1, 1, 0);
        @(negedge CLK);
        check("f9_dv", 32'(Data_Valid), 32'h1);
        check("f9_pdata", 32'(P_DATA), 32'hEE);

        repeat (3) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
